// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: one shift-add/subtract step per cycle,
// exact signed or unsigned 2*WIDTH-bit product after exactly WIDTH cycles.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic        [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic signed [WIDTH:0]   mcand_q, mcand_d;
  logic                    signed_q, signed_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic        [WIDTH-1:0] hi_q, hi_d;
  logic        [WIDTH-1:0] lo_q, lo_d;

  logic signed [WIDTH+1:0] sum;
  logic                    last;

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    last     = (cnt_q == LAST);

    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so the
    // final step subtracts the multiplicand instead of adding it.
    sum = $signed({acc_hi_q[WIDTH], acc_hi_q});
    if (acc_lo_q[0]) begin
      if (last && signed_q)
        sum = sum - $signed({mcand_q[WIDTH], mcand_q});
      else
        sum = sum + $signed({mcand_q[WIDTH], mcand_q});
    end

    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (Start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          mcand_d  = Signed ? $signed({A[WIDTH-1], A}) : $signed({1'b0, A});
          acc_hi_d = '0;
          acc_lo_d = B;
          signed_d = Signed;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_hi_d = sum[WIDTH+1:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = sum[WIDTH:1];
          lo_d    = {sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 32-bit and 8-bit instances, hand-computed products.
module tb_seq_multiplier;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0, Signed = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  logic        start8 = 1'b0, signed8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] prev_exp = '0;
  int          done_seen;

  seq_multiplier #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .Start(start8), .Signed(signed8),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8), .Hi(hi8), .Lo(lo8)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called just after a rising edge; leaves the bench just after the Done edge
  // (chain=1) or one cycle later (chain=0).
  task automatic mul32(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp,
                       input bit interfere, input bit chain);
    Start = 1'b1; Signed = sgn; A = a; B = b;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk({tag, "_busy0"}, 64'(Busy), 64'd1);
    for (int i = 1; i < 32; i++) begin
      if (interfere && i == 10) begin
        Start = 1'b1; A = ~a; B = b + 32'd3; Signed = ~sgn;
      end else if (interfere && i == 11) begin
        Start = 1'b0;
      end
      @(posedge Clock); #1;
    end
    chk({tag, "_busy31"}, 64'(Busy), 64'd1);
    chk({tag, "_nodone31"}, 64'(Done), 64'd0);
    chk({tag, "_hold"}, {Hi, Lo}, prev_exp);
    @(posedge Clock); #1;
    chk({tag, "_done"}, 64'(Done), 64'd1);
    chk({tag, "_busyoff"}, 64'(Busy), 64'd0);
    chk({tag, "_prod"}, {Hi, Lo}, exp);
    prev_exp = exp;
    if (!chain) begin
      @(posedge Clock); #1;
      chk({tag, "_pulse"}, 64'(Done), 64'd0);
      chk({tag, "_keep"}, {Hi, Lo}, exp);
    end
  endtask

  task automatic mul8(input string tag, input logic sgn, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    start8 = 1'b1; signed8 = sgn; a8 = a; b8 = b;
    @(posedge Clock); #1;
    start8 = 1'b0;
    repeat (7) @(posedge Clock);
    #1;
    chk({tag, "_busy7"}, 64'(busy8), 64'd1);
    @(posedge Clock); #1;
    chk({tag, "_done"}, 64'(done8), 64'd1);
    chk({tag, "_prod"}, 64'({hi8, lo8}), 64'(exp));
    @(posedge Clock); #1;
  endtask

  initial begin
    #2;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_prod", {Hi, Lo}, 64'd0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;

    mul32("neg3x5",   1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
    mul32("5xneg3",   1'b1, 32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
    mul32("uones",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
    mul32("sones",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 0);
    mul32("minmin",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0);
    mul32("minx1",    1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 0, 0);
    mul32("ignstart", 1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 1, 1);
    mul32("b2b",      1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 0, 0);

    // Abort mid-run with an asynchronous reset between edges
    Start = 1'b1; Signed = 1'b0; A = 32'd1000; B = 32'd1000;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (16) @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_prod", {Hi, Lo}, 64'd0);
    #1 Reset = 1'b0;
    prev_exp = '0;
    done_seen = 0;
    repeat (40) begin
      @(posedge Clock); #1;
      if (Done) done_seen++;
    end
    chk("abort_nodone", 64'(done_seen), 64'd0);
    chk("abort_idle", 64'(Busy), 64'd0);

    // Start on the very first edge after reset release
    Reset = 1'b1;
    #1 Reset = 1'b0;
    mul32("postrst", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0, 0);

    mul8("w8s", 1'b1, 8'h80, 8'h7F, 16'hC080);
    mul8("w8u", 1'b0, 8'h80, 8'h7F, 16'h3F80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
